// File: rtl/tl_buffer_param.sv
// TileLink A/D channel buffer: two independent parameterised FIFOs with optional flow-bypass and pipe-ready.
// Define TL_BUFFER_OCCUPANCY_EN to expose registered count and sticky peak occupancy per queue.

module tl_buffer_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef TL_BUFFER_OCCUPANCY_EN
  ,
  output logic [CW-1:0] occ,
  output logic [CW-1:0] occ_peak
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [1 << PW];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          empty, enq, deq, bypass, do_wr, do_rd;

  assign empty     = (count == '0);
  assign in_ready  = (count != FULL) | ((PIPE != 0) & out_ready);
  assign out_valid = !empty | ((FLOW != 0) & in_valid);
  assign out_data  = ((FLOW != 0) && empty) ? in_data : mem[rd_ptr];

  assign enq    = in_valid & in_ready;
  assign deq    = out_valid & out_ready;
  // an empty flow queue hands the beat straight through without touching storage
  assign bypass = (FLOW != 0) & empty & deq;
  assign do_wr  = enq & !bypass;
  assign do_rd  = deq & !bypass;

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)
      count_nxt = count + CW'(1);
    else if (!do_wr && do_rd)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (do_wr)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_rd)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
    end
  end

  // storage is deliberately left unreset
  always_ff @(posedge clock) begin
    if (do_wr)
      mem[wr_ptr] <= in_data;
  end

`ifdef TL_BUFFER_OCCUPANCY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      occ_peak <= '0;
    else if (count_nxt > occ_peak)
      occ_peak <= count_nxt;
  end

  assign occ = count;
`endif

endmodule

module tl_buffer_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SOURCE_W = 4,
  parameter int SIZE_W   = 4,
  parameter int A_DEPTH  = 2,
  parameter int D_DEPTH  = 2,
  parameter int A_FLOW   = 0,
  parameter int A_PIPE   = 0,
  parameter int D_FLOW   = 0,
  parameter int D_PIPE   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  a_in_valid,
  output logic                  a_in_ready,
  input  logic [2:0]            a_in_opcode,
  input  logic [2:0]            a_in_param,
  input  logic [SIZE_W-1:0]     a_in_size,
  input  logic [SOURCE_W-1:0]   a_in_source,
  input  logic [ADDR_W-1:0]     a_in_address,
  input  logic [DATA_W/8-1:0]   a_in_mask,
  input  logic [DATA_W-1:0]     a_in_data,
  input  logic                  a_in_corrupt,
  output logic                  a_out_valid,
  input  logic                  a_out_ready,
  output logic [2:0]            a_out_opcode,
  output logic [2:0]            a_out_param,
  output logic [SIZE_W-1:0]     a_out_size,
  output logic [SOURCE_W-1:0]   a_out_source,
  output logic [ADDR_W-1:0]     a_out_address,
  output logic [DATA_W/8-1:0]   a_out_mask,
  output logic [DATA_W-1:0]     a_out_data,
  output logic                  a_out_corrupt,
  input  logic                  d_in_valid,
  output logic                  d_in_ready,
  input  logic [2:0]            d_in_opcode,
  input  logic [1:0]            d_in_param,
  input  logic [SIZE_W-1:0]     d_in_size,
  input  logic [SOURCE_W-1:0]   d_in_source,
  input  logic                  d_in_sink,
  input  logic                  d_in_denied,
  input  logic [DATA_W-1:0]     d_in_data,
  input  logic                  d_in_corrupt,
  output logic                  d_out_valid,
  input  logic                  d_out_ready,
  output logic [2:0]            d_out_opcode,
  output logic [1:0]            d_out_param,
  output logic [SIZE_W-1:0]     d_out_size,
  output logic [SOURCE_W-1:0]   d_out_source,
  output logic                  d_out_sink,
  output logic                  d_out_denied,
  output logic [DATA_W-1:0]     d_out_data,
  output logic                  d_out_corrupt
`ifdef TL_BUFFER_OCCUPANCY_EN
  ,
  output logic [$clog2(A_DEPTH+1)-1:0] a_count,
  output logic [$clog2(A_DEPTH+1)-1:0] a_peak,
  output logic [$clog2(D_DEPTH+1)-1:0] d_count,
  output logic [$clog2(D_DEPTH+1)-1:0] d_peak
`endif
);

  localparam int MASK_W = DATA_W / 8;
  localparam int A_W    = 3 + 3 + SIZE_W + SOURCE_W + ADDR_W + MASK_W + DATA_W + 1;
  localparam int D_W    = 3 + 2 + SIZE_W + SOURCE_W + 1 + 1 + DATA_W + 1;

  logic [A_W-1:0] a_in_pl, a_out_pl;
  logic [D_W-1:0] d_in_pl, d_out_pl;

  // payloads are carried opaquely as one flat word per beat
  assign a_in_pl = {a_in_opcode, a_in_param, a_in_size, a_in_source,
                    a_in_address, a_in_mask, a_in_data, a_in_corrupt};
  assign {a_out_opcode, a_out_param, a_out_size, a_out_source,
          a_out_address, a_out_mask, a_out_data, a_out_corrupt} = a_out_pl;

  assign d_in_pl = {d_in_opcode, d_in_param, d_in_size, d_in_source,
                    d_in_sink, d_in_denied, d_in_data, d_in_corrupt};
  assign {d_out_opcode, d_out_param, d_out_size, d_out_source,
          d_out_sink, d_out_denied, d_out_data, d_out_corrupt} = d_out_pl;

  tl_buffer_queue #(.W(A_W), .DEPTH(A_DEPTH), .FLOW(A_FLOW), .PIPE(A_PIPE)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_pl),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_pl)
`ifdef TL_BUFFER_OCCUPANCY_EN
    ,
    .occ       (a_count),
    .occ_peak  (a_peak)
`endif
  );

  tl_buffer_queue #(.W(D_W), .DEPTH(D_DEPTH), .FLOW(D_FLOW), .PIPE(D_PIPE)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_data   (d_in_pl),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_data  (d_out_pl)
`ifdef TL_BUFFER_OCCUPANCY_EN
    ,
    .occ       (d_count),
    .occ_peak  (d_peak)
`endif
  );

endmodule

// File: tb/tb_tl_buffer_param.sv
// Bench for tl_buffer_param: two instances (plain A/D depth 2/3, and A flow + D depth-1 pipe) against a queue model.
module tb_tl_buffer_param;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } a_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [3:0]  source;
    logic        sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } d_t;

  typedef logic [95:0] pl_t;

  // channel 0: dut0 A, 1: dut0 D, 2: dut1 A, 3: dut1 D
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] ivld, ordy, irdy, ovld;
  pl_t        ch_in [4];
  pl_t        ch_out[4];
  a_t         a0_in, a1_in, a0_out, a1_out;
  d_t         d0_in, d1_in, d0_out, d1_out;

  int depth[4] = '{2, 3, 2, 1};
  bit flow [4] = '{0, 0, 1, 0};
  bit pipe [4] = '{0, 0, 0, 1};
  pl_t q[4][$];
  int  peak_m[4];
  int  total = 0;
  int  bad   = 0;

  assign a0_in = a_t'(ch_in[0][$bits(a_t)-1:0]);
  assign d0_in = d_t'(ch_in[1][$bits(d_t)-1:0]);
  assign a1_in = a_t'(ch_in[2][$bits(a_t)-1:0]);
  assign d1_in = d_t'(ch_in[3][$bits(d_t)-1:0]);
  assign ch_out[0] = pl_t'(a0_out);
  assign ch_out[1] = pl_t'(d0_out);
  assign ch_out[2] = pl_t'(a1_out);
  assign ch_out[3] = pl_t'(d1_out);

`ifdef TL_BUFFER_OCCUPANCY_EN
  logic [1:0] a0_cnt, a0_pk, d0_cnt, d0_pk, a1_cnt, a1_pk;
  logic       d1_cnt, d1_pk;
`endif

  always #5 clock = ~clock;

  tl_buffer_param #(.A_DEPTH(2), .D_DEPTH(3)) dut0 (
    .clock(clock), .reset(reset),
    .a_in_valid(ivld[0]), .a_in_ready(irdy[0]),
    .a_in_opcode(a0_in.opcode), .a_in_param(a0_in.param), .a_in_size(a0_in.size),
    .a_in_source(a0_in.source), .a_in_address(a0_in.address), .a_in_mask(a0_in.mask),
    .a_in_data(a0_in.data), .a_in_corrupt(a0_in.corrupt),
    .a_out_valid(ovld[0]), .a_out_ready(ordy[0]),
    .a_out_opcode(a0_out.opcode), .a_out_param(a0_out.param), .a_out_size(a0_out.size),
    .a_out_source(a0_out.source), .a_out_address(a0_out.address), .a_out_mask(a0_out.mask),
    .a_out_data(a0_out.data), .a_out_corrupt(a0_out.corrupt),
    .d_in_valid(ivld[1]), .d_in_ready(irdy[1]),
    .d_in_opcode(d0_in.opcode), .d_in_param(d0_in.param), .d_in_size(d0_in.size),
    .d_in_source(d0_in.source), .d_in_sink(d0_in.sink), .d_in_denied(d0_in.denied),
    .d_in_data(d0_in.data), .d_in_corrupt(d0_in.corrupt),
    .d_out_valid(ovld[1]), .d_out_ready(ordy[1]),
    .d_out_opcode(d0_out.opcode), .d_out_param(d0_out.param), .d_out_size(d0_out.size),
    .d_out_source(d0_out.source), .d_out_sink(d0_out.sink), .d_out_denied(d0_out.denied),
    .d_out_data(d0_out.data), .d_out_corrupt(d0_out.corrupt)
`ifdef TL_BUFFER_OCCUPANCY_EN
    , .a_count(a0_cnt), .a_peak(a0_pk), .d_count(d0_cnt), .d_peak(d0_pk)
`endif
  );

  tl_buffer_param #(.A_FLOW(1), .D_DEPTH(1), .D_PIPE(1)) dut1 (
    .clock(clock), .reset(reset),
    .a_in_valid(ivld[2]), .a_in_ready(irdy[2]),
    .a_in_opcode(a1_in.opcode), .a_in_param(a1_in.param), .a_in_size(a1_in.size),
    .a_in_source(a1_in.source), .a_in_address(a1_in.address), .a_in_mask(a1_in.mask),
    .a_in_data(a1_in.data), .a_in_corrupt(a1_in.corrupt),
    .a_out_valid(ovld[2]), .a_out_ready(ordy[2]),
    .a_out_opcode(a1_out.opcode), .a_out_param(a1_out.param), .a_out_size(a1_out.size),
    .a_out_source(a1_out.source), .a_out_address(a1_out.address), .a_out_mask(a1_out.mask),
    .a_out_data(a1_out.data), .a_out_corrupt(a1_out.corrupt),
    .d_in_valid(ivld[3]), .d_in_ready(irdy[3]),
    .d_in_opcode(d1_in.opcode), .d_in_param(d1_in.param), .d_in_size(d1_in.size),
    .d_in_source(d1_in.source), .d_in_sink(d1_in.sink), .d_in_denied(d1_in.denied),
    .d_in_data(d1_in.data), .d_in_corrupt(d1_in.corrupt),
    .d_out_valid(ovld[3]), .d_out_ready(ordy[3]),
    .d_out_opcode(d1_out.opcode), .d_out_param(d1_out.param), .d_out_size(d1_out.size),
    .d_out_source(d1_out.source), .d_out_sink(d1_out.sink), .d_out_denied(d1_out.denied),
    .d_out_data(d1_out.data), .d_out_corrupt(d1_out.corrupt)
`ifdef TL_BUFFER_OCCUPANCY_EN
    , .a_count(a1_cnt), .a_peak(a1_pk), .d_count(d1_cnt), .d_peak(d1_pk)
`endif
  );

  // reference model: a plain queue per channel plus the handshake rules
  function automatic bit exp_ready(int c);
    return (q[c].size() < depth[c]) || (pipe[c] && ordy[c]);
  endfunction

  function automatic bit exp_valid(int c);
    return (q[c].size() > 0) || (flow[c] && ivld[c]);
  endfunction

  function automatic pl_t exp_pl(int c);
    return (q[c].size() > 0) ? q[c][0] : ch_in[c];
  endfunction

  function automatic pl_t rand_pl(int c);
    pl_t v;
    int  w;
    v = {$urandom, $urandom, $urandom};
    w = (c % 2 == 0) ? $bits(a_t) : $bits(d_t);
    return v & ((pl_t'(1) << w) - pl_t'(1));
  endfunction

`ifdef TL_BUFFER_OCCUPANCY_EN
  function automatic int get_cnt(int c);
    case (c)
      0: return int'(a0_cnt);
      1: return int'(d0_cnt);
      2: return int'(a1_cnt);
      default: return int'(d1_cnt);
    endcase
  endfunction

  function automatic int get_pk(int c);
    case (c)
      0: return int'(a0_pk);
      1: return int'(d0_pk);
      2: return int'(a1_pk);
      default: return int'(d1_pk);
    endcase
  endfunction
`endif

  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      q[c].delete();
      peak_m[c] = 0;
    end
  endtask

  // advance one clock: model follows the handshakes implied by current inputs
  task automatic tick();
    bit hs_in[4];
    bit hs_out[4];
    for (int c = 0; c < 4; c++) begin
      hs_in[c]  = ivld[c] && exp_ready(c);
      hs_out[c] = exp_valid(c) && ordy[c];
    end
    @(posedge clock);
    if (reset) begin
      clear_model();
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (!(q[c].size() == 0 && flow[c] && hs_out[c])) begin
          if (hs_out[c]) void'(q[c].pop_front());
          if (hs_in[c]) q[c].push_back(ch_in[c]);
        end
        if (q[c].size() > peak_m[c]) peak_m[c] = q[c].size();
      end
    end
    @(negedge clock);
  endtask

  task automatic idle_all();
    ivld = '0;
    ordy = '0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    #1;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (irdy[c] !== 1'b1) begin bad++; $display("FAIL reset_in_ready ch%0d got=%b exp=1", c, irdy[c]); end
      total++;
      if (ovld[c] !== 1'b0) begin bad++; $display("FAIL reset_out_valid ch%0d got=%b exp=0", c, ovld[c]); end
    end
    ivld[2] = 1'b1;
    ch_in[2] = rand_pl(2);
    #1;
    total++;
    if (ovld[2] !== 1'b1 || ch_out[2] !== ch_in[2]) begin
      bad++; $display("FAIL reset_flow_bypass got_v=%b got=%h exp=%h", ovld[2], ch_out[2], ch_in[2]);
    end
    ivld[2] = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (irdy !== 4'hf) begin bad++; $display("FAIL post_reset_ready got=%b exp=1111", irdy); end
`ifdef TL_BUFFER_OCCUPANCY_EN
    total++;
    if (a0_cnt !== 2'd0 || a0_pk !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d/%0d exp=0/0", a0_cnt, a0_pk); end
`endif
    tick();
  endtask

  task automatic test_a_backpressure();
    a_t sent[3];
    for (int i = 0; i < 3; i++) begin
      sent[i] = a_t'(rand_pl(0));
      sent[i].address = 32'h1000 + 32'(4 * i);
    end
    idle_all();
    ivld[0] = 1'b1;
    ch_in[0] = pl_t'(sent[0]);
    #1;
    total++;
    if (irdy[0] !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b exp=1", irdy[0]); end
    tick();
    ch_in[0] = pl_t'(sent[1]);
    #1;
    total++;
    if (ovld[0] !== 1'b1 || a0_out.address !== 32'h1000) begin
      bad++; $display("FAIL bp_latency got_v=%b addr=%h exp=1/00001000", ovld[0], a0_out.address);
    end
    tick();
    ch_in[0] = pl_t'(sent[2]);
    #1;
    total++;
    if (irdy[0] !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", irdy[0]); end
    tick();
    ordy[0] = 1'b1;
    #1;
    total++;
    if (irdy[0] !== 1'b0 || a0_out.address !== 32'h1000) begin
      bad++; $display("FAIL bp_full_nopipe rdy=%b addr=%h exp=0/00001000", irdy[0], a0_out.address);
    end
    tick();
    #1;
    total++;
    if (irdy[0] !== 1'b1 || a0_out.address !== 32'h1004) begin
      bad++; $display("FAIL bp_second rdy=%b addr=%h exp=1/00001004", irdy[0], a0_out.address);
    end
    tick();
    ivld[0] = 1'b0;
    #1;
    total++;
    if (ovld[0] !== 1'b1 || ch_out[0] !== pl_t'(sent[2])) begin
      bad++; $display("FAIL bp_third v=%b got=%h exp=%h", ovld[0], ch_out[0], pl_t'(sent[2]));
    end
    tick();
    #1;
    total++;
    if (ovld[0] !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", ovld[0]); end
    idle_all();
  endtask

  task automatic test_d_order();
    pl_t beats[7];
    pl_t got[$];
    d_t  t;
    int  ns = 0;
    int  cyc = 0;
    for (int i = 0; i < 7; i++) begin
      t = d_t'(rand_pl(1));
      t.sink    = (i == 3);
      t.denied  = (i == 3);
      t.corrupt = (i == 3);
      beats[i] = pl_t'(t);
    end
    idle_all();
    while (got.size() < 7 && cyc < 200) begin
      ivld[1] = (ns < 7);
      ch_in[1] = (ns < 7) ? beats[ns] : '0;
      ordy[1] = $urandom_range(0, 1);
      #1;
      total++;
      if (irdy[1] !== exp_ready(1)) begin bad++; $display("FAIL order_ready got=%b exp=%b", irdy[1], exp_ready(1)); end
      total++;
      if (ovld[1] !== exp_valid(1)) begin bad++; $display("FAIL order_valid got=%b exp=%b", ovld[1], exp_valid(1)); end
      if (exp_valid(1)) begin
        total++;
        if (ch_out[1] !== exp_pl(1)) begin bad++; $display("FAIL order_payload got=%h exp=%h", ch_out[1], exp_pl(1)); end
        if (ordy[1]) got.push_back(ch_out[1]);
      end
      if (ivld[1] && exp_ready(1)) ns++;
      tick();
      cyc++;
    end
    total++;
    if (got.size() != 7) begin bad++; $display("FAIL order_timeout got=%0d exp=7", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      total++;
      if (got[i] !== beats[i]) begin bad++; $display("FAIL order_seq idx=%0d got=%h exp=%h", i, got[i], beats[i]); end
    end
    if (got.size() > 3) begin
      t = d_t'(got[3][$bits(d_t)-1:0]);
      total++;
      if ({t.sink, t.denied, t.corrupt} !== 3'b111) begin bad++; $display("FAIL denied_pass got=%b exp=111", {t.sink, t.denied, t.corrupt}); end
    end
    idle_all();
  endtask

  task automatic test_a_flow();
    a_t t;
    idle_all();
    t = a_t'(rand_pl(2));
    t.data = 32'hDEADBEEF;
    ch_in[2] = pl_t'(t);
    ivld[2] = 1'b1;
    ordy[2] = 1'b1;
    #1;
    total++;
    if (ovld[2] !== 1'b1 || a1_out.data !== 32'hDEADBEEF || ch_out[2] !== pl_t'(t)) begin
      bad++; $display("FAIL flow_same_cycle v=%b data=%h exp=1/deadbeef", ovld[2], a1_out.data);
    end
    tick();
    ivld[2] = 1'b0;
    #1;
    total++;
    if (ovld[2] !== 1'b0) begin bad++; $display("FAIL flow_not_stored got=%b exp=0", ovld[2]); end
`ifdef TL_BUFFER_OCCUPANCY_EN
    total++;
    if (a1_cnt !== 2'd0 || a1_pk !== 2'd0) begin bad++; $display("FAIL flow_count got=%0d/%0d exp=0/0", a1_cnt, a1_pk); end
`endif
    idle_all();
  endtask

  task automatic test_d_pipe();
    pl_t beats[10];
    for (int i = 0; i < 10; i++) beats[i] = rand_pl(3);
    idle_all();
    ivld[3] = 1'b1;
    ch_in[3] = beats[0];
    tick();
    ch_in[3] = beats[1];
    #1;
    total++;
    if (irdy[3] !== 1'b0) begin bad++; $display("FAIL pipe_full_blocked got=%b exp=0", irdy[3]); end
    ordy[3] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ch_in[3] = beats[i];
      #1;
      total++;
      if (irdy[3] !== 1'b1 || ovld[3] !== 1'b1 || ch_out[3] !== beats[i-1]) begin
        bad++; $display("FAIL pipe_step%0d rdy=%b v=%b got=%h exp=%h", i, irdy[3], ovld[3], ch_out[3], beats[i-1]);
      end
      tick();
`ifdef TL_BUFFER_OCCUPANCY_EN
      total++;
      if (d1_cnt !== 1'b1) begin bad++; $display("FAIL pipe_count%0d got=%0d exp=1", i, d1_cnt); end
`endif
    end
    ivld[3] = 1'b0;
    #1;
    total++;
    if (ch_out[3] !== beats[8]) begin bad++; $display("FAIL pipe_last got=%h exp=%h", ch_out[3], beats[8]); end
    tick();
    #1;
    total++;
    if (ovld[3] !== 1'b0) begin bad++; $display("FAIL pipe_drained got=%b exp=0", ovld[3]); end
    idle_all();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        ivld[c] = ($urandom_range(0, 99) < 60);
        ordy[c] = ($urandom_range(0, 99) < 50);
        ch_in[c] = rand_pl(c);
      end
      #1;
      for (int c = 0; c < 4; c++) begin
        total++;
        if (irdy[c] !== exp_ready(c)) begin bad++; $display("FAIL rand_ready ch%0d n=%0d got=%b exp=%b", c, n, irdy[c], exp_ready(c)); end
        total++;
        if (ovld[c] !== exp_valid(c)) begin bad++; $display("FAIL rand_valid ch%0d n=%0d got=%b exp=%b", c, n, ovld[c], exp_valid(c)); end
        if (exp_valid(c)) begin
          total++;
          if (ch_out[c] !== exp_pl(c)) begin bad++; $display("FAIL rand_payload ch%0d n=%0d got=%h exp=%h", c, n, ch_out[c], exp_pl(c)); end
        end
`ifdef TL_BUFFER_OCCUPANCY_EN
        total++;
        if (get_cnt(c) != q[c].size() || get_pk(c) != peak_m[c]) begin
          bad++; $display("FAIL rand_occ ch%0d got=%0d/%0d exp=%0d/%0d", c, get_cnt(c), get_pk(c), q[c].size(), peak_m[c]);
        end
`endif
      end
      tick();
    end
    idle_all();
  endtask

  task automatic test_reset_mid();
    pl_t p;
    idle_all();
    // drain anything left over from the random phase
    for (int c = 0; c < 4; c++) ordy[c] = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle_all();
    ivld[0] = 1'b1;
    ch_in[0] = rand_pl(0);
    tick();
    ch_in[0] = rand_pl(0);
    tick();
    ivld[0] = 1'b0;
    #1;
    total++;
    if (ovld[0] !== 1'b1 || irdy[0] !== 1'b0) begin bad++; $display("FAIL mid_prefill v=%b rdy=%b exp=1/0", ovld[0], irdy[0]); end
    #1;
    reset = 1'b1;
    clear_model();
    #1;
    total++;
    if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1) begin bad++; $display("FAIL mid_reset_async v=%b rdy=%b exp=0/1", ovld[0], irdy[0]); end
`ifdef TL_BUFFER_OCCUPANCY_EN
    total++;
    if (a0_cnt !== 2'd0 || a0_pk !== 2'd0) begin bad++; $display("FAIL mid_reset_occ got=%0d/%0d exp=0/0", a0_cnt, a0_pk); end
`endif
    tick();
    reset = 1'b0;
    p = rand_pl(0);
    ivld[0] = 1'b1;
    ch_in[0] = p;
    tick();
    ivld[0] = 1'b0;
    #1;
    total++;
    if (ovld[0] !== 1'b1 || ch_out[0] !== p) begin bad++; $display("FAIL first_after_reset v=%b got=%h exp=%h", ovld[0], ch_out[0], p); end
    ordy[0] = 1'b1;
    tick();
    idle_all();
  endtask

  initial begin
    reset = 1'b1;
    ivld = '0;
    ordy = '0;
    for (int c = 0; c < 4; c++) ch_in[c] = '0;
    clear_model();
    test_reset();
    test_a_backpressure();
    test_d_order();
    test_a_flow();
    test_d_pipe();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
